// File: rtl/fetch_u.sv
// fetch_u: instruction fetch stage with PC, req/ack imem reads, instruction register and redirects
module fetch_u #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] instr,
    output logic [31:0] ir_pc,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] jtarget,
    input  logic        jump,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] hold_pc;

    assign op_code = instr[31:26];
    assign funct   = instr[5:0];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm     = instr[15:0];
    assign jtarget = instr[25:0];

    // redirect target is word aligned; jump keeps the top nibble of the sequential pc
    always_comb begin
        rpc     = {redirect_pc[31:2], 2'b00};
        jpc     = {pc[31:28], jtarget, 2'b00};
        hold_pc = redirect ? rpc : (jump ? jpc : pc);
    end

    // fetch state machine: pc, request handshake and instruction register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir_valid  <= 1'b0;
            instr     <= 32'h0;
            ir_pc     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    pc        <= redirect ? rpc : pc;
                    imem_addr <= redirect ? rpc : pc;
                    imem_req  <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pc       <= rpc;
                        ir_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || ir_ready) begin
                        pc        <= hold_pc;
                        imem_addr <= hold_pc;
                        ir_valid  <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
                default: begin
                    if (redirect) pc <= rpc;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    // saturating count of cycles with an unanswered request
    always_comb begin
        cnt_nxt = (!imem_req || imem_ack) ? 32'h0 : ((cnt == ACK_TIMEOUT) ? cnt : cnt + 32'd1);
    end

    // sticky timeout flag, only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (ACK_TIMEOUT != 0 && cnt_nxt == ACK_TIMEOUT) fetch_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_u.sv
// tb_fetch_u: directed self-checking bench for fetch_u
module tb_fetch_u;
    logic        clk = 1'b0;
    logic        rst_n, imem_ack, ir_ready, jump, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, ir_valid, fetch_err;
    logic [31:0] imem_addr, instr, ir_pc;
    logic [5:0]  op_code, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jtarget;

    logic        rst_n1, imem_ack1, ir_ready1;
    logic [31:0] imem_rdata1;
    logic        imem_req1, ir_valid1, fetch_err1;
    logic [31:0] imem_addr1, instr1, ir_pc1;
    logic [5:0]  op_code1, funct1;
    logic [4:0]  rs1, rt1, rd1;
    logic [15:0] imm1;
    logic [25:0] jtarget1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_u u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .instr(instr), .ir_pc(ir_pc), .op_code(op_code), .funct(funct), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .jtarget(jtarget), .jump(jump), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_err(fetch_err)
    );

    fetch_u #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(255)) u1 (
        .clk(clk), .rst_n(rst_n1), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .ir_valid(ir_valid1), .ir_ready(ir_ready1),
        .instr(instr1), .ir_pc(ir_pc1), .op_code(op_code1), .funct(funct1), .rs(rs1), .rt(rt1),
        .rd(rd1), .imm(imm1), .jtarget(jtarget1), .jump(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .fetch_err(fetch_err1)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0; ir_ready = 1'b0;
        jump = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rst_n1 = 1'b0; imem_ack1 = 1'b0; imem_rdata1 = 32'h0; ir_ready1 = 1'b0;
        tick(3);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_irpc", ir_pc, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1; imem_ack = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        // ack latency 0
        imem_ack = 1'b1; imem_rdata = 32'h0230_8020;
        tick();
        imem_ack = 1'b0;
        chk("i0_valid", 32'(ir_valid), 32'h1);
        chk("i0_op", 32'(op_code), 32'd0);
        chk("i0_funct", 32'(funct), 32'd32);
        chk("i0_irpc", ir_pc, 32'h0);
        chk("i0_rs", 32'(rs), 32'd17);
        chk("i0_rt", 32'(rt), 32'd16);
        chk("i0_rd", 32'(rd), 32'd16);
        chk("i0_req", 32'(imem_req), 32'h0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("i1_valid_drop", 32'(ir_valid), 32'h0);
        chk("i1_req", 32'(imem_req), 32'h1);
        chk("i1_addr", imem_addr, 32'h4);
        // ack latency 2
        tick(2);
        chk("i1_wait_valid", 32'(ir_valid), 32'h0);
        chk("i1_wait_addr", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'h0230_8022;
        tick();
        imem_ack = 1'b0;
        chk("i1_valid", 32'(ir_valid), 32'h1);
        chk("i1_funct", 32'(funct), 32'd34);
        chk("i1_irpc", ir_pc, 32'h4);
        chk("i1_op", 32'(op_code), 32'd0);
        // backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_instr", instr, 32'h0230_8022);
            chk("bp_irpc", ir_pc, 32'h4);
            chk("bp_req", 32'(imem_req), 32'h0);
            chk("bp_valid", 32'(ir_valid), 32'h1);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("bp_next_addr", imem_addr, 32'h8);
        chk("bp_next_req", 32'(imem_req), 32'h1);
        // redirect from HOLD to reach 0x100
        imem_ack = 1'b1; imem_rdata = 32'h0;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("hold_redir_addr", imem_addr, 32'h100);
        chk("hold_redir_valid", 32'(ir_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
        tick();
        imem_ack = 1'b0;
        chk("j_irpc", ir_pc, 32'h100);
        chk("j_target", 32'(jtarget), 32'h10);
        jump = 1'b1; ir_ready = 1'b1;
        tick();
        jump = 1'b0; ir_ready = 1'b0;
        chk("j_addr", imem_addr, 32'h40);
        chk("j_req", 32'(imem_req), 32'h1);
        // jump without ir_ready is ignored
        imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
        tick();
        imem_ack = 1'b0;
        chk("nj_irpc", ir_pc, 32'h40);
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk("nj_valid", 32'(ir_valid), 32'h1);
        chk("nj_req", 32'(imem_req), 32'h0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("nj_addr", imem_addr, 32'h44);
        // redirect during FETCH without ack -> drain
        redirect = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        redirect = 1'b0;
        chk("dr_req", 32'(imem_req), 32'h1);
        chk("dr_old_addr", imem_addr, 32'h44);
        tick(2);
        chk("dr_hold_addr", imem_addr, 32'h44);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("dr_valid", 32'(ir_valid), 32'h0);
        chk("dr_req_drop", 32'(imem_req), 32'h0);
        tick();
        chk("dr_new_req", 32'(imem_req), 32'h1);
        chk("dr_new_addr", imem_addr, 32'h200);
        chk("dr_valid2", 32'(ir_valid), 32'h0);
        // redirect on the ack cycle -> IDLE then fetch
        redirect = 1'b1; redirect_pc = 32'h0000_0201; imem_ack = 1'b1;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("ra_req", 32'(imem_req), 32'h0);
        chk("ra_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("ra_req2", 32'(imem_req), 32'h1);
        chk("ra_addr", imem_addr, 32'h200);
        chk("u0_err", 32'(fetch_err), 32'h0);
        // timeout and pc wrap on second instance
        rst_n1 = 1'b1;
        tick();
        chk("to_addr", imem_addr1, 32'hFFFF_FFFC);
        chk("to_req", 32'(imem_req1), 32'h1);
        tick(250);
        chk("to_err_early", 32'(fetch_err1), 32'h0);
        tick(5);
        chk("to_err", 32'(fetch_err1), 32'h1);
        chk("to_req_held", 32'(imem_req1), 32'h1);
        imem_ack1 = 1'b1; imem_rdata1 = 32'h1234_5678;
        tick();
        imem_ack1 = 1'b0;
        chk("to_irpc", ir_pc1, 32'hFFFF_FFFC);
        chk("to_valid", 32'(ir_valid1), 32'h1);
        chk("to_err_sticky", 32'(fetch_err1), 32'h1);
        ir_ready1 = 1'b1;
        tick();
        ir_ready1 = 1'b0;
        chk("wrap_addr", imem_addr1, 32'h0);
        chk("wrap_req", 32'(imem_req1), 32'h1);
        chk("wrap_err", 32'(fetch_err1), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
